systolic_tile_fifo: RTL and testbench
=====================================

// Module: systolic_tile_fifo
// PURPOSE
//  8x8 output-stationary systolic matrix-multiply tile with one edge FIFO per row input and per column input.
//  FIFOs are first loaded with pre-skewed operand streams. The array then drains them and accumulates C = A x B, one element per PE.
//  Sits between the operand loader (upstream) and the result readout logic (downstream).
// PARAMETERS
//  N           8    array dimension; N row FIFOs, N column FIFOs, NxN PEs
//  DATA_W      16   operand/accumulator width
//  FIFO_DEPTH  32   entries per edge FIFO; power of 2, >= 3N-1
// PORTS
//  CLK          in   1             single clock, rising edge
//  RST_N        in   1             asynchronous, active-low reset
//  EN           in   1             array enable; 0 = all PE state holds
//  FIFO_EN      in   1             FIFO enable; 0 = all FIFO state holds
//  FIFO_WRITE   in   1             1 = push R_DIN/C_DIN; 0 = pop (when FIFO_EN)
//  R_DIN        in   N*DATA_W      row-FIFO write data; lane i = bits [i*DATA_W +: DATA_W]
//  C_DIN        in   N*DATA_W      column-FIFO write data; lane j likewise
//  Y            out  N*N*DATA_W    accumulators; C[i][j] at [(i*N+j)*DATA_W +: DATA_W]
//  R_EDGE_OUT   out  N*DATA_W      row operand leaving PE(i,N-1) to the east
//  C_EDGE_OUT   out  N*DATA_W      column operand leaving PE(N-1,j) to the south
//  FIFO_STATUS  out  2N*4          per FIFO f (rows 0..N-1, then cols N..2N-1): {ALMOST_FULL, ALMOST_EMPTY, FULL, EMPTY}
// BEHAVIOUR
//  Reset (async, RST_N=0)
//   - All FIFO pointers, counts and DATA_OUT regs clear to 0.
//   - All PE accumulators and pass regs clear to 0.
//   - Y, R_EDGE_OUT, C_EDGE_OUT = 0; every FIFO reports EMPTY=1, ALMOST_EMPTY=1.
//   - Reset mid-operation discards all content immediately.
//  Edge FIFO, per lane, on CLK edge with FIFO_EN=1
//   - FIFO_WRITE=1: store DIN if not FULL, else drop; DATA_OUT unchanged; no pop.
//   - FIFO_WRITE=0: if not EMPTY, DATA_OUT <= oldest entry and pop; if EMPTY, DATA_OUT <= 0 and pointers unchanged.
//   - Read latency 1 cycle (registered DATA_OUT); pointers wrap modulo FIFO_DEPTH.
//   - FIFO_EN=0: full hold.
//   - Flags are combinational from count: EMPTY count==0; ALMOST_EMPTY count<=1; FULL count==FIFO_DEPTH; ALMOST_FULL count>=FIFO_DEPTH-1.
//  PE(i,j), on CLK edge with EN=1
//   - acc <= acc + x_in*y_in, truncated to DATA_W (mod 2^16), unsigned.
//   - x_out <= x_in; y_out <= y_in.
//  Array wiring
//   - x_in(i,0) = row FIFO i DATA_OUT; x_in(i,j) = x_out(i,j-1).
//   - y_in(0,j) = col FIFO j DATA_OUT; y_in(i,j) = y_out(i-1,j).
//   - Y[i][j] = acc(i,j), registered.
//  Operand format
//   - Row i stream carries A[i][k] at slot i+k; column j stream carries B[k][j] at slot j+k; zero elsewhere.
//   - Hence PE(i,j) pairs A[i][k] with B[k][j].
//   - Result is final 3N-1 cycles (plus 1 FIFO latency) after the first pop with EN=FIFO_EN=1, FIFO_WRITE=0.
//  Feeding zeros after the FIFOs empty leaves all results unchanged; EN=0 freezes results indefinitely.
// TESTING
//  1. Reset -> all Y=0; all 16 FIFO_STATUS = 4'b0101.
//  2. Push 24 pre-skewed slots per lane (lane i: i zeros, then 1..8, then zeros; EN=0) -> counts 24, EMPTY=0, FULL=0, Y still 0.
//  3. After step 2, set FIFO_WRITE=0 and EN=1 for 25 cycles -> every Y[i][j]=204 (sum k^2, k=1..8); FIFOs EMPTY.
//  4. Push 33 words into one FIFO -> ALMOST_FULL at 31, FULL at 32, 33rd word dropped; pops then return words 1..32 in order, then 0.
//  5. Deassert EN for 5 cycles mid-compute, then resume -> final Y identical to step 3.
//  6. Operands 300 x 300 in one lane -> acc wraps to (90000 mod 65536)=24464; RST_N low mid-run -> all Y=0 asynchronously.

Source files
------------

// File: rtl/systolic_tile_fifo.sv
// 8x8 output-stationary systolic matmul tile fed by 2N edge FIFOs.
// CLK/RST_N, EN, FIFO_EN, FIFO_WRITE, R_DIN/C_DIN in; Y, edge outs, FIFO_STATUS out.
module systolic_tile_fifo #(
  parameter int N          = 8,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic                    FIFO_EN,
  input  logic                    FIFO_WRITE,
  input  logic [N*DATA_W-1:0]     R_DIN,
  input  logic [N*DATA_W-1:0]     C_DIN,
  output logic [N*N*DATA_W-1:0]   Y,
  output logic [N*DATA_W-1:0]     R_EDGE_OUT,
  output logic [N*DATA_W-1:0]     C_EDGE_OUT,
  output logic [2*N*4-1:0]        FIFO_STATUS
);

  localparam int L  = 2 * N;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] AE_C   = CW'(1);

  logic [DATA_W-1:0] fd [L];

  for (genvar f = 0; f < L; f++) begin : g_fifo
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] dout;
    logic              empty;
    logic              full;

    if (f < N) begin : g_row
      assign din = R_DIN[f*DATA_W +: DATA_W];
    end else begin : g_col
      assign din = C_DIN[(f-N)*DATA_W +: DATA_W];
    end

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_C);
    assign FIFO_STATUS[f*4 +: 4] =
      {(cnt >= AF_C), (cnt <= AE_C), full, empty};
    assign fd[f] = dout;

    always_ff @(posedge CLK) begin
      if (FIFO_EN && FIFO_WRITE && !full)
        mem[wptr] <= din;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
        dout <= '0;
      end else if (FIFO_EN) begin
        if (FIFO_WRITE) begin
          if (!full) begin
            wptr <= wptr + 1'b1;
            cnt  <= cnt + 1'b1;
          end
        end else if (!empty) begin
          dout <= mem[rptr];
          rptr <= rptr + 1'b1;
          cnt  <= cnt - 1'b1;
        end else begin
          // Popping an empty lane feeds zeros into the array.
          dout <= '0;
        end
      end
    end
  end

  logic [DATA_W-1:0] xr  [N][N];
  logic [DATA_W-1:0] yr  [N][N];
  logic [DATA_W-1:0] acc [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row_pe
    for (genvar j = 0; j < N; j++) begin : g_col_pe
      logic [DATA_W-1:0] xi;
      logic [DATA_W-1:0] yi;

      if (j == 0) begin : g_xw
        assign xi = fd[i];
      end else begin : g_xi
        assign xi = xr[i][j-1];
      end

      if (i == 0) begin : g_yn
        assign yi = fd[N+j];
      end else begin : g_yi
        assign yi = yr[i-1][j];
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          xr[i][j]  <= '0;
          yr[i][j]  <= '0;
          acc[i][j] <= '0;
        end else if (EN) begin
          xr[i][j]  <= xi;
          yr[i][j]  <= yi;
          acc[i][j] <= acc[i][j] + xi * yi;
        end
      end

      assign Y[(i*N+j)*DATA_W +: DATA_W] = acc[i][j];
    end
    assign R_EDGE_OUT[i*DATA_W +: DATA_W] = xr[i][N-1];
    assign C_EDGE_OUT[i*DATA_W +: DATA_W] = yr[N-1][i];
  end

endmodule

// File: tb/tb_systolic_tile_fifo.sv
// Directed bench for systolic_tile_fifo.
// Linear steps with immediate assertions and a pass/fail tally.
module tb_systolic_tile_fifo;

  localparam int N  = 8;
  localparam int DW = 16;

  logic CLK = 1'b0;
  logic RST_N;
  logic EN;
  logic FIFO_EN;
  logic FIFO_WRITE;
  logic [N*DW-1:0]   R_DIN;
  logic [N*DW-1:0]   C_DIN;
  logic [N*N*DW-1:0] Y;
  logic [N*DW-1:0]   R_EDGE_OUT;
  logic [N*DW-1:0]   C_EDGE_OUT;
  logic [2*N*4-1:0]  FIFO_STATUS;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  systolic_tile_fifo dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .FIFO_EN(FIFO_EN),
    .FIFO_WRITE(FIFO_WRITE), .R_DIN(R_DIN), .C_DIN(C_DIN),
    .Y(Y), .R_EDGE_OUT(R_EDGE_OUT), .C_EDGE_OUT(C_EDGE_OUT),
    .FIFO_STATUS(FIFO_STATUS)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] y_at(input int i, input int j);
    return Y[(i*N+j)*DW +: DW];
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_y(input string tag, input logic [DW-1:0] v);
    int bad = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (y_at(i, j) !== v) bad++;
    chk(tag, 128'(bad), 128'd0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
    step();
  endtask

  // Lane s slot value: lane zeros, then 1..8, then zeros.
  task automatic push_skewed();
    EN = 1'b0;
    FIFO_EN = 1'b1;
    FIFO_WRITE = 1'b1;
    for (int s = 0; s < 24; s++) begin
      for (int l = 0; l < N; l++) begin
        logic [DW-1:0] v;
        v = (s >= l && s < l + 8) ? DW'(s - l + 1) : '0;
        R_DIN[l*DW +: DW] = v;
        C_DIN[l*DW +: DW] = v;
      end
      step();
    end
    R_DIN = '0;
    C_DIN = '0;
  endtask

  initial begin
    logic [2*N*4-1:0] st_empty;
    st_empty = {16{4'b0101}};
    RST_N = 1'b1;
    EN = 1'b0;
    FIFO_EN = 1'b0;
    FIFO_WRITE = 1'b0;
    R_DIN = '0;
    C_DIN = '0;
    #3;

    // 1: reset state
    RST_N = 1'b0;
    #2;
    chk_all_y("reset_y", 16'd0);
    chk("reset_status", 128'(FIFO_STATUS), 128'(st_empty));
    chk("reset_redge", 128'(R_EDGE_OUT), 128'd0);
    RST_N = 1'b1;
    step();

    // 2: load skewed streams
    push_skewed();
    chk("load_status", 128'(FIFO_STATUS), 128'd0);
    chk_all_y("load_y", 16'd0);

    // 3: compute
    FIFO_WRITE = 1'b0;
    EN = 1'b1;
    for (int c = 0; c < 25; c++) step();
    chk_all_y("mm_y204", 16'd204);
    chk("mm_y77", 128'(y_at(7, 7)), 128'd204);
    chk("mm_status", 128'(FIFO_STATUS), 128'(st_empty));

    // 4: fill one FIFO past full, then drain through the array
    do_reset();
    EN = 1'b0;
    FIFO_EN = 1'b1;
    FIFO_WRITE = 1'b1;
    for (int w = 1; w <= 33; w++) begin
      R_DIN[DW-1:0] = DW'(w);
      step();
      if (w == 30) chk("cnt30", 128'(FIFO_STATUS[3:0]), 128'(4'b0000));
      if (w == 31) chk("cnt31_af", 128'(FIFO_STATUS[3:0]), 128'(4'b1000));
      if (w == 32) chk("cnt32_full", 128'(FIFO_STATUS[3:0]), 128'(4'b1010));
      if (w == 33) chk("cnt33_full", 128'(FIFO_STATUS[3:0]), 128'(4'b1010));
    end
    R_DIN = '0;
    FIFO_WRITE = 1'b0;
    EN = 1'b1;
    for (int k = 0; k < N + 34; k++) begin
      logic [DW-1:0] ex;
      step();
      ex = (k >= N && k - N + 1 <= 32) ? DW'(k - N + 1) : '0;
      chk($sformatf("drain_%0d", k), 128'(R_EDGE_OUT[DW-1:0]), 128'(ex));
    end
    chk("drain_status", 128'(FIFO_STATUS[3:0]), 128'(4'b0101));
    chk("drain_cedge", 128'(C_EDGE_OUT), 128'd0);
    chk_all_y("drain_y", 16'd0);

    // 5: freeze mid-compute, then resume
    do_reset();
    push_skewed();
    FIFO_WRITE = 1'b0;
    EN = 1'b1;
    for (int c = 0; c < 10; c++) step();
    EN = 1'b0;
    FIFO_EN = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("frz_y00", 128'(y_at(0, 0)), 128'd204);
    chk("frz_y77", 128'(y_at(7, 7)), 128'd0);
    chk("frz_status", 128'(FIFO_STATUS[3:0]), 128'(4'b0000));
    EN = 1'b1;
    FIFO_EN = 1'b1;
    for (int c = 0; c < 20; c++) step();
    chk_all_y("resume_y204", 16'd204);

    // 6: wraparound, then async reset mid-run
    do_reset();
    EN = 1'b0;
    FIFO_WRITE = 1'b1;
    R_DIN[DW-1:0] = 16'd300;
    C_DIN[DW-1:0] = 16'd300;
    step();
    R_DIN = '0;
    C_DIN = '0;
    FIFO_WRITE = 1'b0;
    EN = 1'b1;
    for (int c = 0; c < 4; c++) step();
    chk("wrap_y00", 128'(y_at(0, 0)), 128'd24464);
    chk("wrap_y01", 128'(y_at(0, 1)), 128'd0);
    chk("wrap_y10", 128'(y_at(1, 0)), 128'd0);
    RST_N = 1'b0;
    #1;
    chk_all_y("async_rst_y", 16'd0);
    chk("async_rst_status", 128'(FIFO_STATUS), 128'(st_empty));
    RST_N = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
